// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction memory
// for the current PC and hands the returned word to decode through a
// valid/ready register. A misaligned PC or a bus error yields a faulting NOP.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | nothing issued, all outputs low; moves to REQ next cycle
//  REQ   | request presented for pc (or fault captured if misaligned)
//  WAIT  | request accepted, waiting for its response
//  DRAIN | request accepted but flushed; swallow its response
//  FULL  | instruction register valid, waiting for decode or flush
module ifetch_unit #(
    parameter int                WIDTH  = 32,
    parameter int                IWIDTH = 32,
    parameter logic [IWIDTH-1:0] NOP    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pc,
    input  logic              flush,
    output logic              pc_adv,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WIDTH-1:0]  imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [IWIDTH-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [IWIDTH-1:0] instr,
    output logic [WIDTH-1:0]  instr_pc,
    output logic              instr_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        FULL  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] issued_pc;
    logic             misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    // Request and handshake outputs decoded from the registered state.
    always_comb begin
        imem_req_valid = (state == REQ) && !misaligned;
        imem_addr      = (state == REQ) ? pc : '0;
        instr_valid    = (state == FULL);
        pc_adv         = (state == FULL) && instr_ready && !flush;
    end

    // Fetch sequencing; the instruction register is only non-zero while in
    // FULL so that every other state presents all-low outputs to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            issued_pc   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (misaligned) begin
                        instr       <= NOP;
                        instr_pc    <= pc;
                        instr_fault <= 1'b1;
                        state       <= FULL;
                    end else if (imem_req_ready && !flush) begin
                        issued_pc <= pc;
                        state     <= WAIT;
                    end else if (imem_req_ready) begin
                        state <= DRAIN;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (flush) begin
                            state <= REQ;
                        end else begin
                            instr       <= imem_rsp_err ? NOP : imem_rsp_data;
                            instr_pc    <= issued_pc;
                            instr_fault <= imem_rsp_err;
                            state       <= FULL;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) state <= REQ;
                end
                FULL: begin
                    if (flush || instr_ready) begin
                        instr       <= '0;
                        instr_pc    <= '0;
                        instr_fault <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by a randomized run
// against a simple memory model. The reference is architectural: whenever an
// instruction is offered to decode it must be the memory word at the current
// PC (or a faulting NOP for a misaligned PC or a bus-error address).
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        pc_adv;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    int checks = 0;
    int errors = 0;

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .flush          (flush),
        .pc_adv         (pc_adv),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[4:2] == 3'd5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ivalid"}, instr_valid, 0);
        check({tag, "_rvalid"}, imem_req_valid, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_ipc"}, instr_pc, 0);
        check({tag, "_fault"}, instr_fault, 0);
        check({tag, "_adv"}, pc_adv, 0);
    endtask

    // random-phase state
    logic        acc_q, adv_q, flush_q, pend;
    logic [31:0] tgt, tgt_q, addr_q, paddr;
    int          dly;
    int          delivered;
    logic [31:0] exp_instr;
    logic        exp_fault;

    initial begin
        rst = 1'b1; pc = 32'h100; flush = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0; instr_ready = 0;
        repeat (2) tick();
        #2;
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        #2;
        check_all_zero("idle");

        // basic fetch at 0x100
        tick();
        imem_req_ready = 1;
        #2;
        check("t2_req_valid", imem_req_valid, 1);
        check("t2_addr", imem_addr, 32'h100);
        tick();
        imem_req_ready = 0;
        imem_rsp_valid = 1; imem_rsp_data = 32'h0050_0093; imem_rsp_err = 0;
        #2;
        check("t2_wait_ivalid", instr_valid, 0);
        check("t2_wait_rvalid", imem_req_valid, 0);
        tick();
        imem_rsp_valid = 0; instr_ready = 1;
        #2;
        check("t2_ivalid", instr_valid, 1);
        check("t2_instr", instr, 32'h0050_0093);
        check("t2_ipc", instr_pc, 32'h100);
        check("t2_fault", instr_fault, 0);
        check("t2_adv", pc_adv, 1);
        check("t2_excl", imem_req_valid, 0);
        tick();
        pc = 32'h40; instr_ready = 0;
        #2;
        check("t2_adv_once", pc_adv, 0);
        check("t2_ivalid_drop", instr_valid, 0);

        // request held while memory stalls
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", imem_req_valid, 1);
            check("t3_hold_addr", imem_addr, 32'h40);
            tick();
            #2;
        end
        imem_req_ready = 1;
        #1;
        check("t3_valid_c4", imem_req_valid, 1);
        tick();
        imem_req_ready = 0;

        // flush while waiting, late response discarded
        flush = 1;
        #2;
        tick();
        flush = 0; pc = 32'h80;
        #2;
        check("t4_drain_ivalid", instr_valid, 0);
        check("t4_drain_rvalid", imem_req_valid, 0);
        tick();
        imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD;
        #2;
        check("t4_rsp_ivalid", instr_valid, 0);
        tick();
        imem_rsp_valid = 0;
        #2;
        check("t4_after_ivalid", instr_valid, 0);
        check("t4_new_req", imem_req_valid, 1);
        check("t4_new_addr", imem_addr, 32'h80);

        // redirect to misaligned target
        flush = 1;
        tick();
        flush = 0; pc = 32'h102;
        #2;
        check("t5_idle_rvalid", imem_req_valid, 0);
        tick();
        #2;
        check("t5_no_req", imem_req_valid, 0);
        tick();
        #2;
        check("t5_ivalid", instr_valid, 1);
        check("t5_fault", instr_fault, 1);
        check("t5_instr", instr, NOP);
        check("t5_ipc", instr_pc, 32'h102);
        check("t5_no_req_full", imem_req_valid, 0);

        // decode stalls four cycles, then flush together with ready
        for (int i = 0; i < 4; i++) begin
            check("t6_stall_valid", instr_valid, 1);
            check("t6_stall_instr", instr, NOP);
            check("t6_stall_ipc", instr_pc, 32'h102);
            check("t6_stall_fault", instr_fault, 1);
            check("t6_stall_adv", pc_adv, 0);
            tick();
            #2;
        end
        flush = 1; instr_ready = 1;
        #1;
        check("t6_flush_adv", pc_adv, 0);
        tick();
        flush = 0; instr_ready = 0; pc = 32'h200;
        #2;
        check("t6_ivalid_drop", instr_valid, 0);
        check("t6_req", imem_req_valid, 1);
        check("t6_addr", imem_addr, 32'h200);

        // async reset in the middle of WAIT
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0;
        #2;
        rst = 1;
        #1;
        check_all_zero("t1_rst");
        tick();
        rst = 0;
        #2;
        check_all_zero("t1_idle");
        tick();
        #2;
        check("t1_req", imem_req_valid, 1);
        check("t1_addr", imem_addr, 32'h200);

        // randomized run
        pend = 0; dly = 0; delivered = 0; tgt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (instr_valid) begin
                exp_fault = (pc[1:0] != 2'b00) || mem_err(pc);
                exp_instr = exp_fault ? NOP : mem_word(pc);
                check("rnd_ipc", instr_pc, pc);
                check("rnd_instr", instr, exp_instr);
                check("rnd_fault", instr_fault, exp_fault);
            end
            check("rnd_excl", instr_valid && imem_req_valid, 0);
            check("rnd_adv", pc_adv, instr_valid && instr_ready && !flush);
            if (imem_req_valid) begin
                check("rnd_addr", imem_addr, pc);
                check("rnd_align", pc[1:0], 0);
            end
            if (imem_rsp_valid) begin
                check("rnd_rsp_no_req", imem_req_valid, 0);
            end
            acc_q = imem_req_valid && imem_req_ready;
            adv_q = pc_adv; flush_q = flush; tgt_q = tgt; addr_q = imem_addr;
            if (pc_adv) delivered++;

            tick();
            if (flush_q) pc = tgt_q;
            else if (adv_q) pc = pc + 32'd4;
            imem_rsp_valid = 0;
            if (acc_q) begin
                pend = 1; paddr = addr_q; dly = $urandom_range(0, 2);
            end
            if (pend) begin
                if (dly == 0) begin
                    imem_rsp_valid = 1;
                    imem_rsp_data = mem_word(paddr);
                    imem_rsp_err = mem_err(paddr);
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            imem_req_ready = ($urandom_range(0, 99) < 60);
            instr_ready = ($urandom_range(0, 99) < 50);
            flush = ((pc[1:0] == 2'b00) || instr_valid) && ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 15) tgt = 32'($urandom_range(0, 511));
            else tgt = 32'($urandom_range(0, 127)) << 2;
            #2;
        end
        check("rnd_progress", delivered > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
